regtrace_buffer: RTL and testbench
==================================

# regtrace_buffer

Commit-side register trace buffer for the NPC core. It captures every retired instruction's PC and architectural register write into a parametrised FIFO, and drains entries to the simulation host over a valid/ready port. It also keeps a shadow copy of the architectural register file, readable by the difftest and trace logic. It sits between the core's commit stage and the DPI-C trace consumer, and replaces the single-shot register dump with a continuous, lossless-or-flagged stream.

## Interface
Parameters:
- XLEN, 64, data and PC width
- NREG, 32, number of architectural registers (power of two, ≥2)
- DEPTH, 8, FIFO entries (power of two, ≥2)
- DROP_W, 16, drop-counter width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- commit_valid  in  1  one instruction retires this cycle
- commit_pc  in  XLEN  PC of the retiring instruction
- commit_wen  in  1  retiring instruction writes a register
- commit_waddr  in  log2(NREG)  destination register index
- commit_wdata  in  XLEN  value written
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_pc  out  XLEN  head PC
- out_wen  out  1  head write-enable; forced 0 when the head waddr is 0
- out_waddr  out  log2(NREG)  head destination index
- out_wdata  out  XLEN  head data
- level  out  log2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; set when any commit was dropped
- drop_cnt  out  DROP_W  number of dropped commits, saturating
- clr_ovf  in  1  synchronous clear of overflow and drop_cnt
- sh_raddr  in  log2(NREG)  shadow register-file read index
- sh_rdata  out  XLEN  shadow value, combinational; 0 when sh_raddr is 0

## Operation
- **Push:** occurs when commit_valid and (not full, or a pop occurs in the same cycle).
  - The entry written is {commit_pc, commit_wen and (commit_waddr≠0), commit_waddr, commit_wdata}.
- **Pop:** occurs when out_valid and out_ready.
- **Drop:** commit_valid while full with no pop.
  - The entry is discarded and overflow is set.
  - drop_cnt increments and saturates at 2^DROP_W−1.
- **Shadow register file:**
  - Updated on every commit_valid with commit_wen and waddr≠0, whether or not the FIFO entry is dropped.
  - Register 0 is never written and always reads 0.
- **clr_ovf:** clears overflow and drop_cnt.
  - If clr_ovf coincides with a drop, the drop wins: overflow=1, drop_cnt=1.
- **Pointers:** the FIFO is a circular buffer with log2(DEPTH)+1-bit read/write pointers.
  - Pointers wrap naturally.
  - full = (MSBs differ, low bits equal); empty = (pointers equal).
  - level = wptr − rptr.
- **Outputs:** out_* show the head entry, first-word-fall-through.
  - out_* are held stable while out_valid and !out_ready.

## Timing
- Reset values: out_valid=0, level=0, overflow=0, drop_cnt=0, both pointers 0, all shadow registers 0. out_pc, out_waddr and out_wdata read 0.
- Latency: a commit pushed into an empty FIFO at edge N presents out_valid=1 in the cycle after edge N, i.e. 1 cycle. There is no combinational path from commit_* to out_*.
- Simultaneous push and pop:
  - Level unchanged.
  - When full, both are accepted and no drop occurs.
  - When empty, the pop cannot happen (out_valid=0); the push is accepted.
- Shadow write at edge N is visible on sh_rdata in the cycle after edge N. There is no same-cycle bypass.
- Reset asserted mid-operation: all state clears immediately and asynchronously; in-flight entries are lost. Reset deassertion is synchronised externally.
- Handshake: out_valid never drops without a pop. out_ready may be asserted when out_valid=0; it has no effect.

## Structure
- Package regtrace_pkg holds:
  - the entry struct typedef {pc, wen, waddr, wdata}, parametrised by XLEN/NREG via localparams;
  - the clog2-derived width constants.
- Sub-module regtrace_fifo:
  - generic DEPTH×entry circular FIFO with push/pop/full/empty/level;
  - instantiated once.
- The top level holds the drop/overflow logic and the shadow register file.

## Test plan
- **Reset:** assert reset mid-stream with level=5 -> same cycle out_valid=0, level=0, overflow=0; sh_rdata=0 for all indices.
- **Single commit:** pc=0x80000000, waddr=5, wdata=0xDEAD, out_ready=0 -> next cycle out_valid=1, out_pc=0x80000000, out_waddr=5, out_wdata=0xDEAD; sh_raddr=5 reads 0xDEAD.
- **x0 write:** commit waddr=0, wdata=0x1234 -> out_wen=0, sh_rdata(0)=0.
- **Fill and overflow:** DEPTH=8, out_ready=0, 10 commits -> level=8, overflow=1, drop_cnt=2. Then pop 8 -> pcs match the first 8 commits in order.
- **Full with simultaneous push/pop:** level=8, commit_valid and out_ready in the same cycle -> no drop, level stays 8, pointers wrap correctly over 3×DEPTH transfers.
- **clr_ovf collision:** drop_cnt=3, clr_ovf coincides with a drop -> overflow=1, drop_cnt=1. Saturation check with DROP_W=2: 5 drops -> drop_cnt=3.

Source files
------------

// File: rtl/regtrace_pkg.sv
// Shared types and width helpers for the commit-side register trace buffer.
package regtrace_pkg;

  localparam int XLEN_D   = 64;
  localparam int NREG_D   = 32;
  localparam int DEPTH_D  = 8;
  localparam int DROP_W_D = 16;
  localparam int RAW_D    = $clog2(NREG_D);
  localparam int LVW_D    = $clog2(DEPTH_D) + 1;

  typedef struct packed {
    logic [XLEN_D-1:0] pc;
    logic              wen;
    logic [RAW_D-1:0]  waddr;
    logic [XLEN_D-1:0] wdata;
  } entry_t;

  function automatic int ent_w(input int xlen, input int nreg);
    return 2 * xlen + 1 + $clog2(nreg);
  endfunction

endpackage

// File: rtl/regtrace_fifo.sv
// Generic first-word-fall-through circular FIFO with extra-MSB pointers.
module regtrace_fifo
  import regtrace_pkg::*;
#(
  parameter int W     = ent_w(XLEN_D, NREG_D),
  parameter int DEPTH = DEPTH_D,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_pop;

  assign do_pop = pop && !empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;
  assign dout  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/regtrace_buffer.sv
// Commit trace FIFO with drop accounting and a shadow architectural
// register file for difftest/trace readers.
module regtrace_buffer
  import regtrace_pkg::*;
#(
  parameter int XLEN   = XLEN_D,
  parameter int NREG   = NREG_D,
  parameter int DEPTH  = DEPTH_D,
  parameter int DROP_W = DROP_W_D,
  localparam int RAW   = $clog2(NREG),
  localparam int AW    = $clog2(DEPTH),
  localparam int EW    = ent_w(XLEN, NREG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              commit_valid,
  input  logic [XLEN-1:0]   commit_pc,
  input  logic              commit_wen,
  input  logic [RAW-1:0]    commit_waddr,
  input  logic [XLEN-1:0]   commit_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic              out_wen,
  output logic [RAW-1:0]    out_waddr,
  output logic [XLEN-1:0]   out_wdata,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              clr_ovf,
  input  logic [RAW-1:0]    sh_raddr,
  output logic [XLEN-1:0]   sh_rdata
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            wen;
    logic [RAW-1:0]  waddr;
    logic [XLEN-1:0] wdata;
  } ent_t;

  ent_t        din;
  ent_t        head;
  logic [EW-1:0] dout;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        drop;
  logic        rf_we;

  assign pop   = out_valid && out_ready;
  assign push  = commit_valid && (!full || pop);
  assign drop  = commit_valid && full && !pop;
  assign rf_we = commit_valid && commit_wen && (commit_waddr != '0);

  assign din.pc    = commit_pc;
  assign din.wen   = rf_we;
  assign din.waddr = commit_waddr;
  assign din.wdata = commit_wdata;

  regtrace_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign head      = ent_t'(dout);
  assign out_valid = !empty;
  assign out_pc    = head.pc;
  assign out_wen   = head.wen && (head.waddr != '0);
  assign out_waddr = head.waddr;
  assign out_wdata = head.wdata;

  // A drop in the same cycle as a clear still counts as the first drop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)
        drop_cnt <= DROP_W'(1);
      else if (drop_cnt != {DROP_W{1'b1}})
        drop_cnt <= drop_cnt + 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  logic [XLEN-1:0] shadow [NREG];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    end else if (rf_we) begin
      shadow[commit_waddr] <= commit_wdata;
    end
  end

  assign sh_rdata = (sh_raddr == '0) ? '0 : shadow[sh_raddr];

endmodule

// File: tb/tb_regtrace_buffer.sv
// Scoreboard bench for regtrace_buffer: directed commits, queued
// expectations, and a monitor that checks every popped head entry.
module tb_regtrace_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        commit_wen;
  logic [4:0]  commit_waddr;
  logic [63:0] commit_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic        out_wen;
  logic [4:0]  out_waddr;
  logic [63:0] out_wdata;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        clr_ovf;
  logic [4:0]  sh_raddr;
  logic [63:0] sh_rdata;

  logic        s_out_valid;
  logic [63:0] s_out_pc;
  logic        s_out_wen;
  logic [4:0]  s_out_waddr;
  logic [63:0] s_out_wdata;
  logic [3:0]  s_level;
  logic        s_overflow;
  logic [1:0]  s_drop_cnt;
  logic [63:0] s_sh_rdata;

  always #5 clock = ~clock;

  regtrace_buffer u_dut (
    .clock        (clock),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_wen   (commit_wen),
    .commit_waddr (commit_waddr),
    .commit_wdata (commit_wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_wen      (out_wen),
    .out_waddr    (out_waddr),
    .out_wdata    (out_wdata),
    .level        (level),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .clr_ovf      (clr_ovf),
    .sh_raddr     (sh_raddr),
    .sh_rdata     (sh_rdata)
  );

  regtrace_buffer #(.DROP_W(2)) u_sat (
    .clock        (clock),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_wen   (commit_wen),
    .commit_waddr (commit_waddr),
    .commit_wdata (commit_wdata),
    .out_valid    (s_out_valid),
    .out_ready    (out_ready),
    .out_pc       (s_out_pc),
    .out_wen      (s_out_wen),
    .out_waddr    (s_out_waddr),
    .out_wdata    (s_out_wdata),
    .level        (s_level),
    .overflow     (s_overflow),
    .drop_cnt     (s_drop_cnt),
    .clr_ovf      (clr_ovf),
    .sh_raddr     (sh_raddr),
    .sh_rdata     (s_sh_rdata)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL pop_unexpected: got pc %0h expected none", out_pc);
      end else begin
        e = q.pop_front();
        chk("pop_pc", out_pc, e.pc);
        chk("pop_wen", 64'(out_wen), 64'(e.wen));
        chk("pop_waddr", 64'(out_waddr), 64'(e.waddr));
        chk("pop_wdata", out_wdata, e.wdata);
      end
    end
  end

  task automatic cyc(input logic v, input logic w, input logic [63:0] pc,
                     input logic [4:0] wa, input logic [63:0] wd,
                     input logic clr);
    logic acc;
    logic pp;
    commit_valid = v;
    commit_wen   = w;
    commit_pc    = pc;
    commit_waddr = wa;
    commit_wdata = wd;
    clr_ovf      = clr;
    pp  = out_ready && (cnt > 0);
    acc = v && ((cnt < 8) || pp);
    if (acc) q.push_back({pc, w && (wa != 5'd0), wa, wd});
    @(posedge clock);
    #1;
    cnt = cnt + int'(acc) - int'(pp);
    commit_valid = 1'b0;
    clr_ovf      = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 64'h0, 5'd0, 64'h0, 1'b0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && cnt > 0; i++) idle();
    out_ready = 1'b0;
    chk("drain_level", 64'(level), 64'd0);
  endtask

  task automatic sh(input logic [4:0] a, input logic [63:0] e);
    sh_raddr = a;
    #1;
    chk($sformatf("sh_rdata[%0d]", a), sh_rdata, e);
  endtask

  initial begin
    reset        = 1'b1;
    commit_valid = 1'b0;
    commit_pc    = '0;
    commit_wen   = 1'b0;
    commit_waddr = '0;
    commit_wdata = '0;
    out_ready    = 1'b0;
    clr_ovf      = 1'b0;
    sh_raddr     = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_waddr", 64'(out_waddr), 64'd0);
    chk("rst_wdata", out_wdata, 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    cyc(1'b1, 1'b1, 64'h8000_0000, 5'd5, 64'hDEAD, 1'b0);
    chk("one_valid", 64'(out_valid), 64'd1);
    chk("one_pc", out_pc, 64'h8000_0000);
    chk("one_waddr", 64'(out_waddr), 64'd5);
    chk("one_wdata", out_wdata, 64'hDEAD);
    chk("one_wen", 64'(out_wen), 64'd1);
    chk("one_level", 64'(level), 64'd1);
    sh(5'd5, 64'hDEAD);
    idle();
    chk("hold_pc", out_pc, 64'h8000_0000);
    chk("hold_valid", 64'(out_valid), 64'd1);

    cyc(1'b1, 1'b1, 64'h8000_0004, 5'd0, 64'h1234, 1'b0);
    sh(5'd0, 64'd0);
    chk("x0_level", 64'(level), 64'd2);
    cyc(1'b1, 1'b0, 64'h8000_0008, 5'd7, 64'h55, 1'b0);
    sh(5'd7, 64'd0);
    drain();

    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'b1, 64'h100 + 64'(i * 4), 5'(i + 1),
          64'h1000 + 64'(i), 1'b0);
    chk("fill_level", 64'(level), 64'd8);
    chk("fill_ovf", 64'(overflow), 64'd1);
    chk("fill_drop", 64'(drop_cnt), 64'd2);
    chk("fill_drop_w2", 64'(s_drop_cnt), 64'd2);
    sh(5'd10, 64'h1009);
    sh(5'd8, 64'h1007);
    drain();
    chk("post_drain_ovf", 64'(overflow), 64'd1);

    cyc(1'b0, 1'b0, 64'h0, 5'd0, 64'h0, 1'b1);
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_drop", 64'(drop_cnt), 64'd0);

    for (int i = 0; i < 13; i++)
      cyc(1'b1, 1'b1, 64'h200 + 64'(i * 4), 5'(i + 11),
          64'h2000 + 64'(i), 1'b0);
    chk("sat_drop", 64'(drop_cnt), 64'd5);
    chk("sat_drop_w2", 64'(s_drop_cnt), 64'd3);
    cyc(1'b1, 1'b1, 64'h300, 5'd3, 64'h77, 1'b1);
    chk("coll_ovf", 64'(overflow), 64'd1);
    chk("coll_drop", 64'(drop_cnt), 64'd1);
    chk("coll_drop_w2", 64'(s_drop_cnt), 64'd1);
    chk("coll_level", 64'(level), 64'd8);
    sh(5'd3, 64'h77);

    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc(1'b1, 1'b1, 64'h400 + 64'(i * 4), 5'(i % 31 + 1),
          64'h4000 + 64'(i), 1'b0);
      chk("ff_level", 64'(level), 64'd8);
    end
    chk("ff_drop", 64'(drop_cnt), 64'd1);
    drain();

    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b1, 64'h500 + 64'(i * 4), 5'(i + 1),
          64'h5000 + 64'(i), 1'b0);
    chk("mid_level", 64'(level), 64'd5);
    chk("mid_ovf", 64'(overflow), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    for (int a = 0; a < 32; a++) sh(5'(a), 64'd0);
    q.delete();
    cnt = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    cyc(1'b1, 1'b1, 64'hABC0, 5'd9, 64'h99, 1'b0);
    chk("after_rst_pc", out_pc, 64'hABC0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
